// File: rtl/bf_truth_sweep_if.sv
// -----------------------------------------------------------------------------
// bf_truth_sweep_if
//   Bundle of signals between the truth-table sweep engine and its environment.
//   The environment holds the function cell under test and the controller that
//   starts sweeps and reads back the results.
//
//   Parameter
//     N_IN        number of function inputs (1..4); table width T = 2**N_IN
//
//   Signals
//     start       environment -> sweep  begin a sweep (accepted only when idle)
//     exp_tt      environment -> sweep  expected truth table, bit i = vector i
//     y_in        environment -> sweep  function cell output for vec_out
//     vec_out     sweep -> environment  vector applied to the cell, MSB = input A
//     busy        sweep -> environment  high while vectors are being swept
//     done        sweep -> environment  one-cycle pulse, results are final
//     pass        sweep -> environment  last completed sweep had no mismatch
//     tt          sweep -> environment  captured truth table
//     fail_cnt    sweep -> environment  number of mismatching vectors
//     first_fail  sweep -> environment  index of the first mismatch (0 if none)
//
//   Handshake: start is a level sampled on a rising edge; it is consumed on
//   the first edge where the engine is idle and ignored otherwise. done is a
//   single-cycle pulse; pass/tt/fail_cnt/first_fail are valid while done is
//   high and hold until the next accepted start. There is no back-pressure.
//
//   Modports
//     slave   the sweep engine's view
//     master  the environment's view
// -----------------------------------------------------------------------------
interface bf_truth_sweep_if #(
    parameter int N_IN = 3
);
    localparam int T = 2 ** N_IN;

    logic            start;
    logic [T-1:0]    exp_tt;
    logic            y_in;
    logic [N_IN-1:0] vec_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [T-1:0]    tt;
    logic [N_IN:0]   fail_cnt;
    logic [N_IN-1:0] first_fail;

    modport slave (
        input  start, exp_tt, y_in,
        output vec_out, busy, done, pass, tt, fail_cnt, first_fail
    );

    modport master (
        output start, exp_tt, y_in,
        input  vec_out, busy, done, pass, tt, fail_cnt, first_fail
    );
endinterface

// File: rtl/bf_truth_sweep.sv
// -----------------------------------------------------------------------------
// bf_truth_sweep
//   Exhaustive truth-table checker for a small combinational Boolean function.
//   On start it applies every input vector in ascending order, holds each one
//   for SETTLE_CYCLES+1 cycles, samples the cell output on the last of them,
//   builds the captured table and compares it with the expected table.
//
//   Parameters
//     N_IN           number of function inputs, 1..4 (T = 2**N_IN)
//     SETTLE_CYCLES  extra hold cycles per vector before sampling, 0..15
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous, active-high reset
//     bus        bf_truth_sweep_if.slave (see interface file for signals)
//     dbg_state  current FSM state (0 IDLE, 1 SETTLE, 2 DONE)
//
//   Build option
//     BF_SWEEP_STOP_ON_FAIL_EN  when defined the first mismatching vector ends
//                               the sweep; otherwise all T vectors are swept
//                               and every mismatch is counted.
//
//   The done pulse is registered in the DONE state, so it is visible in the
//   cycle after DONE (the block is already back in IDLE then). The results it
//   qualifies were registered on entry to DONE and are therefore stable.
// -----------------------------------------------------------------------------
module bf_truth_sweep #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    bf_truth_sweep_if.slave    bus,
    output logic [1:0]         dbg_state
);
    localparam int T = 2 ** N_IN;

`ifdef BF_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    settle_cnt;
    logic [T-1:0]  exp_lat;

    logic          mismatch;
    logic          last_vec;
    logic          end_sweep;
    logic [N_IN:0] fail_cnt_nxt;

    assign dbg_state = state;

    // Evaluated against the vector currently on vec_out; only used in the
    // sampling cycle of SETTLE (settle_cnt == 0).
    always_comb begin
        mismatch     = (bus.y_in != exp_lat[bus.vec_out]);
        last_vec     = (bus.vec_out == N_IN'(T - 1));
        end_sweep    = last_vec || (STOP_ON_FAIL && mismatch);
        fail_cnt_nxt = bus.fail_cnt + (N_IN + 1)'(mismatch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            settle_cnt     <= 4'd0;
            exp_lat        <= '0;
            bus.vec_out    <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.tt         <= '0;
            bus.fail_cnt   <= '0;
            bus.first_fail <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        exp_lat        <= bus.exp_tt;
                        bus.tt         <= '0;
                        bus.fail_cnt   <= '0;
                        bus.first_fail <= '0;
                        bus.pass       <= 1'b0;
                        bus.vec_out    <= '0;
                        settle_cnt     <= 4'(SETTLE_CYCLES);
                        bus.busy       <= 1'b1;
                        state          <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        bus.tt[bus.vec_out] <= bus.y_in;
                        if (mismatch) begin
                            bus.fail_cnt <= fail_cnt_nxt;
                            // fail_cnt still zero means this is the first miss.
                            if (bus.fail_cnt == '0) begin
                                bus.first_fail <= bus.vec_out;
                            end
                        end
                        if (end_sweep) begin
                            bus.pass <= (fail_cnt_nxt == '0);
                            bus.busy <= 1'b0;
                            state    <= DONE;
                        end else begin
                            bus.vec_out <= bus.vec_out + 1'b1;
                            settle_cnt  <= 4'(SETTLE_CYCLES);
                        end
                    end
                end

                DONE: begin
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bf_truth_sweep.sv
// -----------------------------------------------------------------------------
// tb_bf_truth_sweep
//   Two sweep engines (SETTLE_CYCLES = 2 and 0) each driving a 3-input
//   majority function model. The driver issues start requests and pushes the
//   hand-computed result {latency, tt, pass, fail_cnt, first_fail} into a
//   per-engine queue; a monitor per engine pops and compares on every done.
// -----------------------------------------------------------------------------
module tb_bf_truth_sweep;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bf_truth_sweep_if #(.N_IN(3)) bus2 ();
    bf_truth_sweep_if #(.N_IN(3)) bus0 ();
    logic [1:0] dbg2;
    logic [1:0] dbg0;

    // Majority-of-three cell: {A,B,C} = vec_out.
    assign bus2.y_in = (bus2.vec_out[2] & bus2.vec_out[1]) | (bus2.vec_out[2] & bus2.vec_out[0]) |
                       (bus2.vec_out[1] & bus2.vec_out[0]);
    assign bus0.y_in = (bus0.vec_out[2] & bus0.vec_out[1]) | (bus0.vec_out[2] & bus0.vec_out[0]) |
                       (bus0.vec_out[1] & bus0.vec_out[0]);

    bf_truth_sweep #(.N_IN(3), .SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .dbg_state(dbg2)
    );
    bf_truth_sweep #(.N_IN(3), .SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Packed expectation: [23:16] done latency in edges, [15:8] tt,
    // [7] pass, [6:3] fail_cnt, [2:0] first_fail.
    logic [23:0] exp_q2[$];
    logic [23:0] exp_q0[$];
    longint      t0_q2[$];
    longint      t0_q0[$];
    int          done_cnt2 = 0;
    int          done_cnt0 = 0;
    int          push_cnt2 = 0;
    int          push_cnt0 = 0;

    function automatic logic [23:0] pack(input int lat, input logic [7:0] tt, input logic pass,
                                         input logic [3:0] fc, input logic [2:0] ff);
        return {8'(lat), tt, pass, fc, ff};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic compare(input string dut, input logic [23:0] e, input logic [23:0] a);
        chk({dut, ".latency"},   int'(a[23:16]), int'(e[23:16]));
        chk({dut, ".tt"},        int'(a[15:8]),  int'(e[15:8]));
        chk({dut, ".pass"},      int'(a[7]),     int'(e[7]));
        chk({dut, ".fail_cnt"},  int'(a[6:3]),   int'(e[6:3]));
        chk({dut, ".first_fail"}, int'(a[2:0]),  int'(e[2:0]));
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (bus2.done) begin
            logic [23:0] e;
            longint      t0;
            done_cnt2++;
            if (exp_q2.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL s2.unexpected_done: got done=1, expected no done at t=%0t", $time);
            end else begin
                e  = exp_q2.pop_front();
                t0 = t0_q2.pop_front();
                compare("s2", e, pack(int'(($time - 5 - t0) / 10), bus2.tt, bus2.pass,
                                      4'(bus2.fail_cnt), bus2.first_fail));
            end
        end
    end

    always @(negedge clk) begin
        if (bus0.done) begin
            logic [23:0] e;
            longint      t0;
            done_cnt0++;
            if (exp_q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL s0.unexpected_done: got done=1, expected no done at t=%0t", $time);
            end else begin
                e  = exp_q0.pop_front();
                t0 = t0_q0.pop_front();
                compare("s0", e, pack(int'(($time - 5 - t0) / 10), bus0.tt, bus0.pass,
                                      4'(bus0.fail_cnt), bus0.first_fail));
            end
        end
    end

    // ---------------- driver ----------------
    // Returns 1 time unit after edge k=0 (the edge that samples start).
    task automatic drive_start(input bit sel, input logic [7:0] e_tt, input bit push,
                               input logic [23:0] expv);
        @(negedge clk);
        if (!sel) begin
            bus2.start  = 1'b1;
            bus2.exp_tt = e_tt;
        end else begin
            bus0.start  = 1'b1;
            bus0.exp_tt = e_tt;
        end
        @(posedge clk);
        if (push) begin
            if (!sel) begin
                exp_q2.push_back(expv);
                t0_q2.push_back(longint'($time));
                push_cnt2++;
            end else begin
                exp_q0.push_back(expv);
                t0_q0.push_back(longint'($time));
                push_cnt0++;
            end
        end
        #1;
        bus2.start = 1'b0;
        bus0.start = 1'b0;
    endtask

    task automatic wait_drain(input bit sel, input int budget);
        int n = 0;
        while (((!sel) ? exp_q2.size() : exp_q0.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (((!sel) ? exp_q2.size() : exp_q0.size()) != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.timeout: got no done within %0d cycles, expected done", sel ? "s0" : "s2", budget);
            if (!sel) begin
                exp_q2.delete();
                t0_q2.delete();
            end else begin
                exp_q0.delete();
                t0_q0.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".vec_out"},    int'(bus2.vec_out),    0);
        chk({tag, ".busy"},       int'(bus2.busy),       0);
        chk({tag, ".done"},       int'(bus2.done),       0);
        chk({tag, ".pass"},       int'(bus2.pass),       0);
        chk({tag, ".tt"},         int'(bus2.tt),         0);
        chk({tag, ".fail_cnt"},   int'(bus2.fail_cnt),   0);
        chk({tag, ".first_fail"}, int'(bus2.first_fail), 0);
        chk({tag, ".state"},      int'(dbg2),            0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus2.start  = 1'b0;
        bus2.exp_tt = 8'h00;
        bus0.start  = 1'b0;
        bus0.exp_tt = 8'h00;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Full passing sweep with per-cycle vector/busy tracking.
        drive_start(0, 8'hE8, 1, pack(25, 8'hE8, 1'b1, 4'd0, 3'd0));
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            chk($sformatf("walk.vec_out[k=%0d]", k), int'(bus2.vec_out), (k < 24) ? k / 3 : 7);
            chk($sformatf("walk.busy[k=%0d]", k),    int'(bus2.busy),    (k < 24) ? 1 : 0);
        end
        wait_drain(0, 60);
        chk("walk.vec_out_hold", int'(bus2.vec_out), 7);

`ifdef BF_SWEEP_STOP_ON_FAIL_EN
        drive_start(0, 8'h00, 1, pack(13, 8'h08, 1'b0, 4'd1, 3'd3));
        wait_drain(0, 60);
        drive_start(0, 8'hE0, 1, pack(13, 8'h08, 1'b0, 4'd1, 3'd3));
        wait_drain(0, 60);
        drive_start(0, 8'hE9, 1, pack(4, 8'h00, 1'b0, 4'd1, 3'd0));
        wait_drain(0, 60);
        drive_start(0, 8'hFF, 1, pack(4, 8'h00, 1'b0, 4'd1, 3'd0));
        wait_drain(0, 60);
`else
        drive_start(0, 8'hE9, 1, pack(25, 8'hE8, 1'b0, 4'd1, 3'd0));
        wait_drain(0, 60);
        drive_start(0, 8'h17, 1, pack(25, 8'hE8, 1'b0, 4'd8, 3'd0));
        wait_drain(0, 60);
        drive_start(0, 8'hE0, 1, pack(25, 8'hE8, 1'b0, 4'd1, 3'd3));
        wait_drain(0, 60);
        drive_start(0, 8'h00, 1, pack(25, 8'hE8, 1'b0, 4'd4, 3'd3));
        wait_drain(0, 60);
        drive_start(0, 8'hFF, 1, pack(25, 8'hE8, 1'b0, 4'd4, 3'd0));
        wait_drain(0, 60);
`endif

        // start pulse and exp_tt change at edge 10 must be ignored.
        drive_start(0, 8'hE8, 1, pack(25, 8'hE8, 1'b1, 4'd0, 3'd0));
        repeat (10) @(negedge clk);
        bus2.start  = 1'b1;
        bus2.exp_tt = 8'h00;
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        wait_drain(0, 60);
        repeat (30) @(negedge clk);

        // Reset at edge 10 aborts the sweep without a done pulse.
        drive_start(0, 8'hE8, 0, 24'h0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        repeat (30) @(negedge clk);
        drive_start(0, 8'hE8, 1, pack(25, 8'hE8, 1'b1, 4'd0, 3'd0));
        wait_drain(0, 60);

        // Zero settle cycles: one cycle per vector.
        drive_start(1, 8'hE8, 1, pack(9, 8'hE8, 1'b1, 4'd0, 3'd0));
        wait_drain(1, 40);
`ifdef BF_SWEEP_STOP_ON_FAIL_EN
        drive_start(1, 8'h00, 1, pack(5, 8'h08, 1'b0, 4'd1, 3'd3));
`else
        drive_start(1, 8'h00, 1, pack(9, 8'hE8, 1'b0, 4'd4, 3'd3));
`endif
        wait_drain(1, 40);

        repeat (5) @(negedge clk);
        chk("s2.done_count", done_cnt2, push_cnt2);
        chk("s0.done_count", done_cnt0, push_cnt0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bf_truth_sweep.md
# bf_truth_sweep

Synthesizable exhaustive truth-table checker for small combinational Boolean-function blocks (e.g. the 3-input CMOS function cells). It is the response/capture end of the stimulus loop: on `start` it drives every input vector in ascending order onto the device under test, waits a programmable settle time, samples the single-bit output, and builds the captured truth table. It compares each sample against an expected table and reports `pass`, a mismatch count and the first failing index. It sits beside the function cell in on-chip self-test wrappers and FPGA bring-up tops.

## Interface
- `N_IN`, default 3 — number of function inputs, legal 1..4; table width `T = 2**N_IN`.
- `SETTLE_CYCLES`, default 2 — extra cycles each vector is held before sampling, legal 0..15.
- `clk`  in  1  — single clock; all state changes on rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `start`  in  1  — begin a sweep; honoured only in IDLE.
- `exp_tt`  in  T  — expected truth table; bit i is the expected output for vector i. Latched on accepted `start`.
- `vec_out`  out  N_IN  — registered vector to the DUT, MSB = input A (`{A,B,C} = vec_out` for N_IN=3).
- `y_in`  in  1  — DUT output; combinational from `vec_out`.
- `busy`  out  1  — high while sweeping.
- `done`  out  1  — one-cycle pulse when results are final.
- `pass`  out  1  — 1 when the last completed sweep had zero mismatches.
- `tt`  out  T  — captured truth table.
- `fail_cnt`  out  N_IN+1  — number of mismatching vectors.
- `first_fail`  out  N_IN  — index of the first mismatch; 0 if none.

## Operation
- States: IDLE, SETTLE, DONE.
- IDLE, `start`=1: latch `exp_tt`; clear `tt`, `fail_cnt`, `first_fail`, `pass`; set `vec_out`=0, settle counter=`SETTLE_CYCLES`; go to SETTLE.
- SETTLE, counter≠0: decrement the counter.
- SETTLE, counter=0: write `tt[vec_out]<=y_in`. If `y_in != exp_lat[vec_out]`, increment `fail_cnt`. On the first such mismatch, also load `first_fail<=vec_out`.
  - If `vec_out`=T-1: go to DONE.
  - Otherwise: increment `vec_out` and reload the counter.
- DONE: `done`=1 for this cycle only. `pass=(final fail_cnt==0)` is registered on entry to DONE. Next state is IDLE.
- `vec_out` holds its last value after the sweep. `tt`, `pass`, `fail_cnt` and `first_fail` hold until the next accepted `start`.
- `start` is ignored in SETTLE and DONE. Changes to `exp_tt` after acceptance are ignored.
- `fail_cnt` saturation is impossible: its maximum is T, which fits in N_IN+1 bits.

## Timing
- Reset values: state IDLE; `vec_out`, `busy`, `done`, `pass`, `tt`, `fail_cnt`, `first_fail` all 0.
- Reset asserted mid-sweep aborts the sweep and applies the reset values on the next edge. No `done` pulse is produced.
- Each vector is presented for `SETTLE_CYCLES+1` cycles and sampled on the last of them.
- `busy` is high for every SETTLE cycle. It is low in IDLE and DONE.
- Edge k=0 is the edge that samples `start`. `done` is high during the cycle after edge `T*(SETTLE_CYCLES+1)+1`. Example: N_IN=3, SETTLE_CYCLES=2 gives `done` after edge 25.
- `pass`, `tt`, `fail_cnt` and `first_fail` are valid in the same cycle as `done`.
- A new `start` is accepted the cycle after `done`, when the block is back in IDLE.

## Configuration
- `BF_SWEEP_STOP_ON_FAIL_EN` defined: the first mismatch ends the sweep.
  - That vector's sample and count are recorded (`fail_cnt`=1), then the block goes to DONE.
  - `tt` bits for unswept vectors stay 0.
  - `done` follows `(i+1)*(SETTLE_CYCLES+1)+1` edges after start, where i is the failing index.
- `BF_SWEEP_STOP_ON_FAIL_EN` undefined: all T vectors are always swept, and `fail_cnt` counts every mismatch.

## Test plan
- Majority-function DUT model, N_IN=3, SETTLE=2, `exp_tt`=8'hE8 → `vec_out` steps 0..7, each held 3 cycles. `done` after edge 25, `tt`=8'hE8, `pass`=1, `fail_cnt`=0, `first_fail`=0.
- Same DUT, `exp_tt`=8'hE9 → `pass`=0, `fail_cnt`=1, `first_fail`=0, `tt`=8'hE8. A second run with 8'h17 → `fail_cnt`=8, `first_fail`=0.
- Pulse `start` and change `exp_tt` to 8'h00 at edge 10 of a sweep with 8'hE8 → both ignored. The run completes with `pass`=1 and exactly one `done`.
- Assert `rst` at edge 10 of a sweep → next cycle all outputs 0, state IDLE, no `done`. A subsequent `start` gives a full correct sweep.
- SETTLE_CYCLES=0, `exp_tt`=8'hE8 → one cycle per vector, `done` after edge 9, `pass`=1.
- With `BF_SWEEP_STOP_ON_FAIL_EN`, majority DUT, `exp_tt`=8'h00 → stops at vector 3. `done` after edge 13, `tt`=8'h08, `fail_cnt`=1, `first_fail`=3, `pass`=0.
